factorial_engine: RTL
=====================

// Module: factorial_engine
// PURPOSE
//  Self-sequenced factorial unit: computes n! on a start/done handshake.
//  Successor to the fixed 8-bit factorial datapath. Adds an on-chip FSM
//  controller, a parametrised data width, a sticky overflow flag and an
//  optional saturation mode.
//  Top-level block of the factorial subsystem. Drives the result register
//  that the board display reads.
// PARAMETERS
//  WIDTH     8  accumulator, ALU and result width in bits (>=4)
//  IN_W      4  width of operand n (n ranges 0..2^IN_W-1); IN_W<=WIDTH
//  SATURATE  0  0: result wraps modulo 2^WIDTH on overflow; 1: result clamps to all-ones
// PORTS
//  clk       in   1       rising-edge clock
//  rst_n     in   1       asynchronous active-low reset
//  start     in   1       request; sampled only in IDLE
//  n_i       in   IN_W    operand; captured at the edge that accepts start
//  busy      out  1       high from the accept edge until the DONE state is left
//  done      out  1       one-cycle pulse; result and overflow are valid from this cycle
//  result    out  WIDTH   registered n!, held until the next done
//  overflow  out  1       sticky for the current operation; registered with result
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE, busy=0, done=0,
//   result=0, overflow=0, internal regs N=0, ACC=0.
//  Internal regs: N (IN_W bits, down-counter), ACC (WIDTH bits), OVF (1 bit).
//  FSM states: IDLE, CHECK, MULT, DEC, DONE.
//  - IDLE:  start=1 -> N<=n_i, ACC<=1, OVF<=0, go to CHECK.
//           start=0 -> stay in IDLE.
//  - CHECK: N<=1 -> DONE, else -> MULT. Combinational compare, no register update.
//  - MULT:  full product P = ACC*N (WIDTH+IN_W bits).
//           If P[top IN_W bits] != 0 -> OVF<=1.
//           ACC<=P[WIDTH-1:0]. If SATURATE=1 and overflow is now set,
//           ACC<={WIDTH{1'b1}} and holds there. Go to DEC.
//  - DEC:   N<=N-1. Go to CHECK.
//  - DONE:  result and overflow were loaded on the edge entering DONE.
//           done=1 for exactly this cycle. Unconditionally return to IDLE.
//  Latency: with start accepted at edge E0, done is high in the cycle
//   after edge E(3*max(n-1,0)+1).
//   Examples: n=0 or 1 -> E1; n=5 -> E13.
//  busy=1 in CHECK, MULT, DEC and DONE; busy=0 in IDLE.
//   start may be asserted back-to-back: start in the DONE cycle is ignored,
//   start in the following IDLE cycle is accepted.
//  start while busy: ignored, with no effect on N, ACC or n_i capture.
//  n_i changes after the accept edge: no effect on the operation in flight.
//  Wrap mode (SATURATE=0): each MULT truncates, so the final result equals
//   n! mod 2^WIDTH exactly.
//  overflow stays low if n! < 2^WIDTH, including n=0 and n=1.
//  Reset mid-operation: immediate return to reset values. No done pulse and
//   no partial result reaches the outputs.
//  result and overflow change only on the edge into DONE and on reset.
// STRUCTURE
//  Shared package fact_pkg:
//   - FSM state encoding: 3-bit localparams S_IDLE..S_DONE.
//   - ALU op codes: OP_PASS, OP_MUL, OP_DEC.
//   - Function clog2.
//  One sub-module, fact_alu: parametrised (WIDTH, IN_W), purely
//   combinational. Produces the product, the overflow detect, N-1 and the
//   N<=1 compare.
//  FSM, N/ACC/OVF registers and the output register stay in factorial_engine.
// TESTING
//  1. WIDTH=8, n=5 -> done pulse after edge E13; result=120, overflow=0;
//     busy high E0..E13.
//  2. WIDTH=8, SATURATE=0, n=6 -> result=208 (720 mod 256), overflow=1.
//     Same case with SATURATE=1 -> result=255, overflow=1.
//  3. n=0, then n=1 -> each gives result=1, overflow=0, done after E1.
//  4. WIDTH=16, IN_W=4: n=8 -> result=40320, overflow=0.
//     n=9 -> result=35200, overflow=1.
//  5. n=5 started; start pulsed with n_i=3 at E4; rst_n pulsed low at E7
//     for a partial cycle -> outputs return to 0 asynchronously, no done.
//     Then a new n=3 -> result=6 after E7 from its accept edge.
//  6. Back-to-back: start held high continuously with n=4 -> done pulses
//     every 12 cycles, result=24 each time, no pulse is lost or merged.

Source files
------------

// File: rtl/fact_pkg.sv
// Shared definitions for the factorial subsystem: FSM state encoding,
// ALU operation codes and a small elaboration-time helper.
package fact_pkg;

    // Ceiling log2, used to size the state register from the state count.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    localparam int NUM_STATES = 5;
    localparam int STATE_W    = clog2(NUM_STATES);

    // Controller states; the encoding is fixed so the state value is stable
    // across builds and easy to decode on a probe.
    typedef enum logic [STATE_W-1:0] {
        S_IDLE  = STATE_W'(0),
        S_CHECK = STATE_W'(1),
        S_MULT  = STATE_W'(2),
        S_DEC   = STATE_W'(3),
        S_DONE  = STATE_W'(4)
    } state_e;

    // Datapath operation selected by the controller each cycle.
    typedef enum logic [1:0] {
        OP_PASS = 2'd0,
        OP_MUL  = 2'd1,
        OP_DEC  = 2'd2
    } alu_op_e;

endpackage

// File: rtl/fact_alu.sv
// Combinational datapath of the factorial engine: ACC*N product with
// overflow detect, N-1 decrement and the N<=1 loop-exit compare.
module fact_alu
    import fact_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int IN_W  = 4
) (
    input  alu_op_e          op_i,
    input  logic [WIDTH-1:0] acc_i,
    input  logic [IN_W-1:0]  n_i,
    output logic [WIDTH-1:0] acc_o,
    output logic [IN_W-1:0]  n_o,
    output logic             ovf_o,
    output logic             n_le1_o
);

    logic [WIDTH+IN_W-1:0] prod;

    // Full-width product; any bit above WIDTH means this step overflowed.
    always_comb begin
        prod    = {{IN_W{1'b0}}, acc_i} * {{WIDTH{1'b0}}, n_i};
        acc_o   = acc_i;
        n_o     = n_i;
        ovf_o   = 1'b0;
        n_le1_o = (n_i <= IN_W'(1));
        case (op_i)
            OP_MUL: begin
                acc_o = prod[WIDTH-1:0];
                ovf_o = |prod[WIDTH+IN_W-1:WIDTH];
            end
            OP_DEC: begin
                n_o = n_i - IN_W'(1);
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/factorial_engine.sv
// Self-sequenced factorial unit. A start pulse in IDLE captures n_i, the
// controller then loops CHECK -> MULT -> DEC until N<=1 and publishes the
// accumulated product and its sticky overflow flag on the edge into DONE.
//
// Handshake: start is sampled only while idle (busy=0); the edge that sees
// start=1 in IDLE accepts the request and captures n_i. busy stays high
// until the DONE cycle ends; done is a single-cycle pulse and result /
// overflow are valid from that cycle and held until the next done.
module factorial_engine
    import fact_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int IN_W     = 4,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [IN_W-1:0]  n_i,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             overflow
);

    state_e           state_q, state_d;
    logic [IN_W-1:0]  n_q, n_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             overflow_q, overflow_d;

    alu_op_e          alu_op;
    logic [WIDTH-1:0] alu_acc;
    logic [IN_W-1:0]  alu_n;
    logic             alu_ovf;
    logic             alu_n_le1;

    fact_alu #(
        .WIDTH (WIDTH),
        .IN_W  (IN_W)
    ) u_alu (
        .op_i    (alu_op),
        .acc_i   (acc_q),
        .n_i     (n_q),
        .acc_o   (alu_acc),
        .n_o     (alu_n),
        .ovf_o   (alu_ovf),
        .n_le1_o (alu_n_le1)
    );

    // Next-state and datapath control; every register holds unless its state acts on it.
    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        acc_d      = acc_q;
        ovf_d      = ovf_q;
        result_d   = result_q;
        overflow_d = overflow_q;
        alu_op     = OP_PASS;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    n_d     = n_i;
                    acc_d   = WIDTH'(1);
                    ovf_d   = 1'b0;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (alu_n_le1) begin
                    // Publish only here so partial products never reach the outputs.
                    result_d   = acc_q;
                    overflow_d = ovf_q;
                    state_d    = S_DONE;
                end else begin
                    state_d = S_MULT;
                end
            end
            S_MULT: begin
                alu_op = OP_MUL;
                ovf_d  = ovf_q | alu_ovf;
                // Once saturated the accumulator stays all-ones: any later
                // multiply by N>=2 overflows again and re-clamps.
                acc_d   = (SATURATE && ovf_d) ? {WIDTH{1'b1}} : alu_acc;
                state_d = S_DEC;
            end
            S_DEC: begin
                alu_op  = OP_DEC;
                n_d     = alu_n;
                state_d = S_CHECK;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, working registers and output register with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            n_q        <= '0;
            acc_q      <= '0;
            ovf_q      <= 1'b0;
            result_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            acc_q      <= acc_d;
            ovf_q      <= ovf_d;
            result_q   <= result_d;
            overflow_q <= overflow_d;
        end
    end

    // Status and result outputs decoded straight from registers.
    always_comb begin
        busy     = (state_q != S_IDLE);
        done     = (state_q == S_DONE);
        result   = result_q;
        overflow = overflow_q;
    end

endmodule
